// File: rtl/td_sync_gen_pkg.sv
// Shared video timing package: NTSC-style raster defaults, ITU-656 codes and
// small decode helpers used by the sync generator.
package td_sync_gen_pkg;
  localparam int TD_H_TOTAL     = 858;
  localparam int TD_H_SYNC      = 64;
  localparam int TD_H_ACT_START = 122;
  localparam int TD_H_ACT       = 720;
  localparam int TD_V_TOTAL     = 262;
  localparam int TD_V_SYNC      = 9;
  localparam int TD_V_ACT_START = 20;
  localparam int TD_V_ACT       = 240;

  localparam int HCNT_W = 10;
  localparam int VCNT_W = 9;

  localparam logic [7:0] ITU656_PRE0   = 8'hFF;
  localparam logic [7:0] ITU656_PRE1   = 8'h00;
  localparam logic [7:0] ITU656_SAV_F0 = 8'h80;
  localparam logic [7:0] ITU656_EAV_F0 = 8'h9D;
  localparam logic [7:0] ITU656_SAV_VB = 8'hAB;
  localparam logic [7:0] ITU656_EAV_VB = 8'hB6;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic logic inWin(input int c, input int lo, input int n);
    return (c >= lo) && (c < lo + n);
  endfunction
endpackage

// File: rtl/td_sync_gen_line_counter.sv
// Wrap counter 0..MAX-1 with count enable; carry marks the wrapping step.
module td_line_counter #(
  parameter int MAX = 858,
  parameter int W   = 10
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iEN,
  output logic [W-1:0] oCnt,
  output logic         oCarry
);
  assign oCarry = iEN && (oCnt == W'(MAX - 1));

  always_ff @(posedge iCLK) begin
    if (iRST)     oCnt <= '0;
    else if (iEN) oCnt <= oCarry ? '0 : oCnt + W'(1);
  end
endmodule

// File: rtl/td_sync_gen.sv
// Raster sync generator: h/v counters decoded into registered HS/VS/DE,
// counter position and frame start/count, all one clock behind the counters.
module td_sync_gen
  import td_sync_gen_pkg::*;
#(
  parameter int H_TOTAL     = TD_H_TOTAL,
  parameter int H_SYNC      = TD_H_SYNC,
  parameter int H_ACT_START = TD_H_ACT_START,
  parameter int H_ACT       = TD_H_ACT,
  parameter int V_TOTAL     = TD_V_TOTAL,
  parameter int V_SYNC      = TD_V_SYNC,
  parameter int V_ACT_START = TD_V_ACT_START,
  parameter int V_ACT       = TD_V_ACT
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  output logic              oTD_HS,
  output logic              oTD_VS,
  output logic              oDE,
  output logic [HCNT_W-1:0] oH_CNT,
  output logic [VCNT_W-1:0] oV_CNT,
  output logic              oFrame_Start,
  output logic [7:0]        oFrame_Cnt
);
  if (H_SYNC > H_TOTAL || H_ACT_START + H_ACT > H_TOTAL || H_TOTAL > (1 << HCNT_W)) begin : gBadH
    $error("td_sync_gen: horizontal window exceeds H_TOTAL or counter width");
  end
  if (V_SYNC > V_TOTAL || V_ACT_START + V_ACT > V_TOTAL || V_TOTAL > (1 << VCNT_W)) begin : gBadV
    $error("td_sync_gen: vertical window exceeds V_TOTAL or counter width");
  end

  logic [HCNT_W-1:0] hCnt;
  logic [VCNT_W-1:0] vCnt;
  logic              hWrap, vWrap;
  logic              wrapped;  // a full frame has completed since reset
  logic              atOrigin;
  sync_t             dec;

  td_line_counter #(.MAX(H_TOTAL), .W(HCNT_W)) uHCnt (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .oCnt(hCnt), .oCarry(hWrap));

  td_line_counter #(.MAX(V_TOTAL), .W(VCNT_W)) uVCnt (
    .iCLK(iCLK), .iRST(iRST), .iEN(hWrap), .oCnt(vCnt), .oCarry(vWrap));

  assign atOrigin = (hCnt == '0) && (vCnt == '0);

  always_comb begin
    dec    = '0;
    dec.hs = !(int'(hCnt) < H_SYNC);
    dec.vs = !(int'(vCnt) < V_SYNC);
    dec.de = inWin(int'(hCnt), H_ACT_START, H_ACT) && inWin(int'(vCnt), V_ACT_START, V_ACT);
  end

  // While disabled the position outputs show the held counter, so a resume
  // continues from exactly that pixel.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oTD_HS       <= 1'b1;
      oTD_VS       <= 1'b1;
      oDE          <= 1'b0;
      oFrame_Start <= 1'b0;
      oH_CNT       <= '0;
      oV_CNT       <= '0;
      oFrame_Cnt   <= '0;
      wrapped      <= 1'b0;
    end else begin
      oH_CNT <= hCnt;
      oV_CNT <= vCnt;
      if (vWrap) wrapped <= 1'b1;
      if (iEN) begin
        oTD_HS       <= dec.hs;
        oTD_VS       <= dec.vs;
        oDE          <= dec.de;
        oFrame_Start <= atOrigin;
        if (atOrigin && wrapped) oFrame_Cnt <= oFrame_Cnt + 8'd1;
      end else begin
        oTD_HS       <= 1'b1;
        oTD_VS       <= 1'b1;
        oDE          <= 1'b0;
        oFrame_Start <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_td_sync_gen.sv
// Bench for td_sync_gen on a compact raster: per-cycle model comparison plus
// directed raster, pause and reset scenarios.
module tb_td_sync_gen;
  localparam int H_TOTAL = 40, H_SYNC = 5, H_ACT_START = 8, H_ACT = 24;
  localparam int V_TOTAL = 30, V_SYNC = 3, V_ACT_START = 5, V_ACT = 20;
  localparam int FRAME = H_TOTAL * V_TOTAL;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic oTD_HS, oTD_VS, oDE, oFrame_Start;
  logic [9:0] oH_CNT;
  logic [8:0] oV_CNT;
  logic [7:0] oFrame_Cnt;

  int checks = 0, failures = 0, cyc = 0;

  td_sync_gen #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ACT_START(H_ACT_START), .H_ACT(H_ACT),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_ACT_START(V_ACT_START), .V_ACT(V_ACT)
  ) dut (
    .iCLK(clk), .iRST(rst), .iEN(en), .oTD_HS(oTD_HS), .oTD_VS(oTD_VS), .oDE(oDE),
    .oH_CNT(oH_CNT), .oV_CNT(oV_CNT), .oFrame_Start(oFrame_Start), .oFrame_Cnt(oFrame_Cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: position is just the number of pixels emitted since reset.
  typedef struct { logic hs, vs, de, fs; int h, v, fc; } exp_t;
  exp_t ex;
  int   pos = 0;
  logic mValid = 1'b0;

  function automatic exp_t emit(input int p, input int fc);
    exp_t e;
    e.h  = p % H_TOTAL;
    e.v  = (p / H_TOTAL) % V_TOTAL;
    e.hs = e.h >= H_SYNC;
    e.vs = e.v >= V_SYNC;
    e.de = e.h >= H_ACT_START && e.h < H_ACT_START + H_ACT &&
           e.v >= V_ACT_START && e.v < V_ACT_START + V_ACT;
    e.fs = (p % FRAME) == 0;
    e.fc = fc;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pos    <= 0;
      mValid <= 1'b1;
      ex     <= '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, h: 0, v: 0, fc: 0};
    end else if (en) begin
      ex  <= emit(pos, (pos / FRAME) % 256);
      pos <= pos + 1;
    end else begin
      ex <= '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0,
              h: pos % H_TOTAL, v: (pos / H_TOTAL) % V_TOTAL, fc: ex.fc};
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      chk("m_hs", oTD_HS, ex.hs);
      chk("m_vs", oTD_VS, ex.vs);
      chk("m_de", oDE, ex.de);
      chk("m_fs", oFrame_Start, ex.fs);
      chk("m_h", oH_CNT, ex.h);
      chk("m_v", oV_CNT, ex.v);
      chk("m_fc", oFrame_Cnt, ex.fc);
    end
  end

  // Downstream sync-stability detector: two consecutive VS-low periods
  // holding exactly V_SYNC HS rising edges.
  int   detEdges = 0, detGood = 0, stableAt = -1;
  logic detStable = 1'b0, dPHS = 1'b1, dPVS = 1'b1;
  always @(negedge clk) begin
    if (mValid) begin
      dPHS <= oTD_HS;
      dPVS <= oTD_VS;
      if (!oTD_VS && oTD_HS && !dPHS) detEdges <= detEdges + 1;
      if (oTD_VS && !dPVS) begin
        detEdges <= 0;
        detGood  <= (detEdges == V_SYNC) ? detGood + 1 : 0;
        if (detEdges == V_SYNC && detGood >= 1 && !detStable) begin
          detStable <= 1'b1;
          stableAt  <= cyc;
        end
      end
    end
  end

  int         starts[$];
  logic [7:0] fcs[$];

  task automatic runFrames();
    int vsLow = 0, hsRise = 0, deLines = 0, lineHs = 0, lineDe = 0, deFirst = -1;
    logic pHS = 1'b1;
    for (int c = 0; c < 3 * FRAME + 1; c++) begin
      @(negedge clk);
      if (oFrame_Start) begin
        starts.push_back(cyc);
        fcs.push_back(oFrame_Cnt);
        if (starts.size() == 2) begin
          chk("vs_low_clocks", vsLow, 120);
          chk("hs_rise_in_vs", hsRise, 3);
          chk("de_lines", deLines, 20);
        end
      end
      if (starts.size() == 1) begin
        if (!oTD_VS) vsLow++;
        if (!oTD_VS && oTD_HS && !pHS) hsRise++;
        if (!oTD_HS) lineHs++;
        if (oDE) begin
          if (lineDe == 0) deFirst = int'(oH_CNT);
          lineDe++;
        end
        if (oH_CNT == 10'(H_TOTAL - 1)) begin
          if (lineDe > 0) deLines++;
          if (oV_CNT == 9'd0) begin
            chk("blank_hs_low", lineHs, 5);
            chk("blank_de", lineDe, 0);
          end
          if (oV_CNT == 9'd10) begin
            chk("act_hs_low", lineHs, 5);
            chk("act_de_len", lineDe, 24);
            chk("act_de_start", deFirst, 8);
          end
          lineHs = 0; lineDe = 0; deFirst = -1;
        end
      end
      pHS = oTD_HS;
    end
  endtask

  initial begin
    int   vHeld;
    logic found;
    rst = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hs", oTD_HS, 1); chk("rst_vs", oTD_VS, 1); chk("rst_de", oDE, 0);
    chk("rst_h", oH_CNT, 0);  chk("rst_fc", oFrame_Cnt, 0);
    en = 1'b1;
    @(negedge clk);
    chk("rst_over_en_fs", oFrame_Start, 0);
    chk("rst_over_en_hs", oTD_HS, 1);
    rst = 1'b0;

    runFrames();
    chk("start_count", starts.size(), 4);
    if (starts.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        chk("frame_period", starts[i+1] - starts[i], 1200);
        chk("frame_cnt_at_start", fcs[i+1], i + 1);
      end
      chk("first_fc", fcs[0], 0);
      chk("stable_at_2nd_vs_rise", stableAt, starts[1] + 120);
    end

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (oV_CNT == 9'd7 && oH_CNT == 10'd19) found = 1'b1;
    end
    chk("wait_pause_point", found, 1);
    vHeld = int'(oV_CNT);
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0 || i == 99) begin
        chk("pause_hs", oTD_HS, 1); chk("pause_vs", oTD_VS, 1); chk("pause_de", oDE, 0);
        chk("pause_h", oH_CNT, 20);
        chk("pause_v", oV_CNT, vHeld);
      end
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_h", oH_CNT, 20);
    chk("resume_v", oV_CNT, 7);
    chk("resume_de", oDE, 1);
    chk("resume_hs", oTD_HS, 1);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (oV_CNT == 9'd15) found = 1'b1;
    end
    chk("wait_reset_point", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_hs", oTD_HS, 1); chk("midrst_vs", oTD_VS, 1); chk("midrst_de", oDE, 0);
    chk("midrst_fs", oFrame_Start, 0); chk("midrst_h", oH_CNT, 0);
    chk("midrst_v", oV_CNT, 0); chk("midrst_fc", oFrame_Cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_h", oH_CNT, 0); chk("restart_v", oV_CNT, 0);
    chk("restart_fs", oFrame_Start, 1); chk("restart_fc", oFrame_Cnt, 0);
    repeat (50) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
